sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_mem.sv | 29 ++
 rtl/sync_fifo.sv | 83 ++++++++
 tb/tb_sync_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 16;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered read port.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       read_data <= '0;
    else if (read_en) read_data <= mem[read_addr];
  end

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty status.
// Define SYNC_FIFO_ERR_EN to add registered overflow_o/underflow_o error pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full_o,
  output logic                  empty_o
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow_o,
  output logic                  underflow_o
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full_o    = (count == FULL_COUNT);
  assign empty_o   = (count == '0);
  assign wr_accept = write_en & ~full_o;
  assign rd_accept = read_en & ~empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (wr_accept),
    .write_addr (wr_ptr),
    .write_data (data_in),
    .read_en    (rd_accept),
    .read_addr  (rd_ptr),
    .read_data  (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  // Error pulses flag requests rejected at the edge, one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= write_en & full_o;
      underflow_o <= read_en & empty_o;
    end
  end
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  write_en = 1'b0;
  logic  read_en = 1'b0;
  word_t data_in = '0;
  word_t data_out;
  logic  full_o;
  logic  empty_o;
`ifdef SYNC_FIFO_ERR_EN
  logic  overflow_o;
  logic  underflow_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model
  word_t model_q[$];
  word_t exp_dout = '0;
  logic  exp_ovf  = 1'b0;
  logic  exp_unf  = 1'b0;

  sync_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_en    (write_en),
    .read_en     (read_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .full_o      (full_o),
    .empty_o     (empty_o)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  // Drive one clock of requests and advance the model; returns 1 ns after the edge.
  task automatic cycle(input logic we, input logic re, input word_t din);
    int occ;
    write_en = we;
    read_en  = re;
    data_in  = din;
    @(posedge clk);
    occ     = model_q.size();
    exp_ovf = we && (occ == DEPTH);
    exp_unf = re && (occ == 0);
    if (re && occ > 0) exp_dout = model_q.pop_front();
    if (we && occ < DEPTH) model_q.push_back(din);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n_checks += 3;
    if (empty_o !== 1'b1) begin n_fails++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    if (full_o !== 1'b0) begin n_fails++; $display("FAIL reset_full got=%b exp=0", full_o); end
    if (data_out !== 16'h0) begin n_fails++; $display("FAIL reset_dout got=%h exp=0000", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, word_t'(i));
      n_checks += 2;
      if (empty_o !== 1'b0) begin n_fails++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty_o); end
      if (full_o !== (i == DEPTH - 1)) begin
        n_fails++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full_o, (i == DEPTH - 1));
      end
    end
    cycle(1'b1, 1'b0, 16'hFFFF);
    n_checks += 1;
    if (full_o !== 1'b1) begin n_fails++; $display("FAIL overflow_full got=%b exp=1", full_o); end
`ifdef SYNC_FIFO_ERR_EN
    n_checks += 1;
    if (overflow_o !== 1'b1) begin n_fails++; $display("FAIL overflow_pulse got=%b exp=1", overflow_o); end
    cycle(1'b0, 1'b0, '0);
    n_checks += 1;
    if (overflow_o !== 1'b0) begin n_fails++; $display("FAIL overflow_clear got=%b exp=0", overflow_o); end
`endif
  endtask

  task automatic test_drain(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks += 3;
      if (data_out !== word_t'(i)) begin
        n_fails++; $display("FAIL %s_dout[%0d] got=%h exp=%h", tag, i, data_out, word_t'(i));
      end
      if (full_o !== 1'b0) begin n_fails++; $display("FAIL %s_full[%0d] got=%b exp=0", tag, i, full_o); end
      if (empty_o !== (i == DEPTH - 1)) begin
        n_fails++; $display("FAIL %s_empty[%0d] got=%b exp=%b", tag, i, empty_o, (i == DEPTH - 1));
      end
    end
    cycle(1'b0, 1'b1, '0);
    n_checks += 1;
    if (data_out !== word_t'(DEPTH - 1)) begin
      n_fails++; $display("FAIL %s_underflow_hold got=%h exp=%h", tag, data_out, word_t'(DEPTH - 1));
    end
`ifdef SYNC_FIFO_ERR_EN
    n_checks += 1;
    if (underflow_o !== 1'b1) begin n_fails++; $display("FAIL %s_underflow_pulse got=%b exp=1", tag, underflow_o); end
    cycle(1'b0, 1'b0, '0);
    n_checks += 1;
    if (underflow_o !== 1'b0) begin n_fails++; $display("FAIL %s_underflow_clear got=%b exp=0", tag, underflow_o); end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, word_t'(i));
    test_drain("wrap");
  endtask

  task automatic test_simultaneous();
    word_t expect_q[$];
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, word_t'(16'h100 + i));
      expect_q.push_back(word_t'(16'h100 + i));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, word_t'(16'h200 + i));
      expect_q.push_back(word_t'(16'h200 + i));
      n_checks += 3;
      if (data_out !== expect_q[0]) begin
        n_fails++; $display("FAIL simul_dout[%0d] got=%h exp=%h", i, data_out, expect_q[0]);
      end
      void'(expect_q.pop_front());
      if (empty_o !== 1'b0) begin n_fails++; $display("FAIL simul_empty[%0d] got=%b exp=0", i, empty_o); end
      if (full_o !== 1'b0) begin n_fails++; $display("FAIL simul_full[%0d] got=%b exp=0", i, full_o); end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks += 2;
      if (data_out !== expect_q[0]) begin
        n_fails++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, data_out, expect_q[0]);
      end
      void'(expect_q.pop_front());
      if (empty_o !== (i == 4)) begin
        n_fails++; $display("FAIL simul_count[%0d] empty got=%b exp=%b", i, empty_o, (i == 4));
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, word_t'(16'h300 + i));
    cycle(1'b0, 1'b1, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks += 3;
    if (empty_o !== 1'b1) begin n_fails++; $display("FAIL midrst_empty got=%b exp=1", empty_o); end
    if (full_o !== 1'b0) begin n_fails++; $display("FAIL midrst_full got=%b exp=0", full_o); end
    if (data_out !== 16'h0) begin n_fails++; $display("FAIL midrst_dout got=%h exp=0000", data_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 16'hABCD);
    cycle(1'b0, 1'b1, '0);
    n_checks += 2;
    if (data_out !== 16'hABCD) begin n_fails++; $display("FAIL midrst_read got=%h exp=abcd", data_out); end
    if (empty_o !== 1'b1) begin n_fails++; $display("FAIL midrst_after_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      // Phase the write bias so runs reach both full and empty.
      int wbias = ((i / 100) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(99) < wbias, $urandom_range(99) < 50, word_t'($urandom));
      n_checks += 3;
      if (data_out !== exp_dout) begin n_fails++; $display("FAIL rand_dout[%0d] got=%h exp=%h", i, data_out, exp_dout); end
      if (full_o !== (model_q.size() == DEPTH)) begin
        n_fails++; $display("FAIL rand_full[%0d] got=%b exp=%b", i, full_o, (model_q.size() == DEPTH));
      end
      if (empty_o !== (model_q.size() == 0)) begin
        n_fails++; $display("FAIL rand_empty[%0d] got=%b exp=%b", i, empty_o, (model_q.size() == 0));
      end
`ifdef SYNC_FIFO_ERR_EN
      n_checks += 2;
      if (overflow_o !== exp_ovf) begin n_fails++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, overflow_o, exp_ovf); end
      if (underflow_o !== exp_unf) begin n_fails++; $display("FAIL rand_unf[%0d] got=%b exp=%b", i, underflow_o, exp_unf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain("drain");
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_sync_fifo
